perf_event_dump: RTL and testbench

//  Parametrised cache/CPU performance-event counter bank with a built-in frame serializer.

---
 rtl/perf_event_dump.sv | 211 +++++++++++++++++++++
 tb/tb_perf_event_dump.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_dump.sv
// perf_event_dump: bank of NUM_EVT saturating event counters with a frame
// serializer feeding a uart_tx byte interface.
// Frame layout: HDR_BYTE, then counter 0..NUM_EVT-1, each MSB byte first.
// Optional feature macro: PERF_CHECKSUM_EN appends one byte after the last
// counter byte, the XOR of all counter bytes (header excluded).
module perf_event_dump #(
  parameter int          NUM_EVT  = 8,
  parameter int          CNT_W    = 32,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               dump_i,
  input  logic               tx_busy_i,
  output logic [7:0]         data_o,
  output logic               tx_start_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int TOT_W = NUM_EVT * CNT_W;
  localparam int NB    = TOT_W / 8;
`ifdef PERF_CHECKSUM_EN
  localparam int CS_N  = 1;
`else
  localparam int CS_N  = 0;
`endif
  localparam int LEN   = 1 + NB + CS_N;
  localparam int IDX_W = $clog2(LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SNAP = 3'd1,
    S_SEND = 3'd2,
    S_ACK  = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt     [NUM_EVT];
  logic [CNT_W-1:0]   w_cnt_nxt [NUM_EVT];
  logic [TOT_W-1:0]   w_flat;
  logic [TOT_W-1:0]   r_frame;
  logic [TOT_W-1:0]   w_frame_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [7:0]         w_byte_nxt;
  logic [7:0]         r_data;
  logic               r_start;
  logic               r_busy;
  logic               r_done;
  logic               w_start;
  logic               w_busy;
  logic               w_done;
  logic               w_last;
`ifdef PERF_CHECKSUM_EN
  logic [7:0]         r_csum;
  logic [7:0]         w_csum_nxt;
`endif

  assign w_last     = (r_idx == LAST_IDX);
  assign data_o     = r_data;
  assign tx_start_o = r_start;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

  // Live counter update: clear beats increment, increment saturates at all-ones.
  always_comb begin
    for (int k = 0; k < NUM_EVT; k++) begin
      if (clr_i) begin
        w_cnt_nxt[k] = {CNT_W{1'b0}};
      end else if (evt_i[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
        w_cnt_nxt[k] = r_cnt[k] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        w_cnt_nxt[k] = r_cnt[k];
      end
    end
  end

  // Pack next-cycle counter values with counter 0 in the top bits, so the frame shifts out MSB first.
  always_comb begin
    w_flat = {TOT_W{1'b0}};
    for (int k = 0; k < NUM_EVT; k++) begin
      w_flat[(NUM_EVT-k)*CNT_W-1 -: CNT_W] = w_cnt_nxt[k];
    end
  end

  // Live counter registers; they keep counting in every FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_EVT; k++) r_cnt[k] <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < NUM_EVT; k++) r_cnt[k] <= w_cnt_nxt[k];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic; the ACK cycle hides the uart's start latency on tx_busy_i.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = dump_i ? S_SNAP : S_IDLE;
      S_SNAP:  w_state_nxt = S_SEND;
      S_SEND:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (tx_busy_i)   w_state_nxt = S_WAIT;
        else if (w_last) w_state_nxt = S_DONE;
        else             w_state_nxt = S_SEND;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the outputs can be registered in step with it.
  always_comb begin
    w_start = (w_state_nxt == S_SEND);
    w_busy  = (w_state_nxt != S_IDLE);
    w_done  = (w_state_nxt == S_DONE);
  end

  // Snapshot and byte-pointer next values; the shadow frame shifts after each counter byte.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_frame_nxt = r_frame;
    if (r_state == S_SNAP) begin
      w_idx_nxt   = {IDX_W{1'b0}};
      w_frame_nxt = w_flat;
    end else if ((r_state == S_WAIT) && !tx_busy_i && !w_last) begin
      w_idx_nxt = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
      if (r_idx != {IDX_W{1'b0}}) w_frame_nxt = r_frame << 4'd8;
      else                        w_frame_nxt = r_frame;
    end else begin
      w_idx_nxt   = r_idx;
      w_frame_nxt = r_frame;
    end
  end

`ifdef PERF_CHECKSUM_EN
  // Running XOR of counter bytes, folded in as each counter byte is launched.
  always_comb begin
    w_csum_nxt = r_csum;
    if (r_state == S_SNAP) begin
      w_csum_nxt = 8'h00;
    end else if ((r_state == S_SEND) && (r_idx != {IDX_W{1'b0}}) && !w_last) begin
      w_csum_nxt = r_csum ^ r_frame[TOT_W-1 -: 8];
    end else begin
      w_csum_nxt = r_csum;
    end
  end
`endif

  // Byte that goes out on the next strobe: header, checksum, or top byte of the shadow frame.
  always_comb begin
    w_byte_nxt = 8'h00;
    if (w_idx_nxt == {IDX_W{1'b0}}) begin
      w_byte_nxt = HDR_BYTE;
`ifdef PERF_CHECKSUM_EN
    end else if (w_idx_nxt == LAST_IDX) begin
      w_byte_nxt = w_csum_nxt;
`endif
    end else begin
      w_byte_nxt = w_frame_nxt[TOT_W-1 -: 8];
    end
  end

  // Shadow frame, byte index and checksum registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame <= {TOT_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
`ifdef PERF_CHECKSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      r_frame <= w_frame_nxt;
      r_idx   <= w_idx_nxt;
`ifdef PERF_CHECKSUM_EN
      r_csum  <= w_csum_nxt;
`endif
    end
  end

  // Registered outputs; data_o only changes when a new byte is launched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= 8'h00;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= w_start;
      r_busy  <= w_busy;
      r_done  <= w_done;
      if (w_start) r_data <= w_byte_nxt;
      else         r_data <= r_data;
    end
  end

endmodule

// File: tb/tb_perf_event_dump.sv
// Self-checking bench for perf_event_dump: a frame-level reference model is
// compared against the DUT every cycle, plus literal checks of known frames.
module tb_perf_event_dump;

  localparam int NUM = 8;
  localparam int CW  = 32;
  localparam int BPC = CW / 8;
`ifdef PERF_CHECKSUM_EN
  localparam int LEN  = 1 + NUM * BPC + 1;
  localparam int LEN8 = 4;
`else
  localparam int LEN  = 1 + NUM * BPC;
  localparam int LEN8 = 3;
`endif
  localparam longint unsigned MAXC = (64'd1 << CW) - 64'd1;

  logic           clk  = 1'b0;
  logic           rstn = 1'b0;
  logic [NUM-1:0] evt  = '0;
  logic           clr  = 1'b0;
  logic           dump = 1'b0;
  logic           txb  = 1'b0;
  logic [7:0]     data;
  logic           txs, busy, done;

  logic [1:0]     evt8  = 2'b00;
  logic           dump8 = 1'b0;
  logic           txb8  = 1'b0;
  logic [7:0]     data8;
  logic           txs8, busy8, done8;

  int total = 0;
  int bad   = 0;

  perf_event_dump #(.NUM_EVT(NUM), .CNT_W(CW), .HDR_BYTE(8'hA5)) u_dut (
    .clk(clk), .rstn(rstn), .evt_i(evt), .clr_i(clr), .dump_i(dump),
    .tx_busy_i(txb), .data_o(data), .tx_start_o(txs), .busy_o(busy), .done_o(done));

  perf_event_dump #(.NUM_EVT(2), .CNT_W(8), .HDR_BYTE(8'hA5)) u_dut8 (
    .clk(clk), .rstn(rstn), .evt_i(evt8), .clr_i(1'b0), .dump_i(dump8),
    .tx_busy_i(txb8), .data_o(data8), .tx_start_o(txs8), .busy_o(busy8), .done_o(done8));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // uart model: busy from the cycle after a strobe, for hold_len cycles
  int hold_len = 10;
  int ucnt = 0;
  int uhold = 10;
  initial forever begin
    @(posedge clk); #2;
    if (txs === 1'b1) begin
      uhold = hold_len;
      ucnt  = hold_len + 1;
    end else if (ucnt > 0) begin
      ucnt--;
    end
    txb = (ucnt > 0) && (ucnt <= uhold);
  end

  // captured output streams
  logic [7:0] cap[$];
  logic [7:0] cap8[$];
  int done_cnt  = 0;
  int done8_cnt = 0;

  function automatic logic [63:0] cb(input int i);
    if (i < cap.size()) return {56'd0, cap[i]};
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // reference model: counters as integers, frame as a byte queue
  longint unsigned cm[NUM];
  logic [7:0] expq[$];
  bit         m_busy = 0, m_start = 0, m_done = 0, m_snap = 0;
  logic [7:0] m_data = 8'h00;
  int         m_since = -1;

  initial forever begin
    @(negedge clk);
    if (txs8 === 1'b1) cap8.push_back(data8);
    if (done8 === 1'b1) done8_cnt++;
    if (txs === 1'b1) cap.push_back(data);
    if (done === 1'b1) done_cnt++;
    if (!rstn) begin
      check("rst_start", {63'd0, txs}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_data", {56'd0, data}, 64'd0);
      for (int k = 0; k < NUM; k++) cm[k] = 0;
      expq.delete();
      m_busy = 0; m_start = 0; m_done = 0; m_snap = 0; m_data = 8'h00; m_since = -1;
    end else begin
      bit n_start, n_done, n_busy, n_snap;
      logic [7:0] cs;
      check("busy_o", {63'd0, busy}, {63'd0, m_busy});
      check("tx_start_o", {63'd0, txs}, {63'd0, m_start});
      check("done_o", {63'd0, done}, {63'd0, m_done});
      check("data_o", {56'd0, data}, {56'd0, m_data});
      n_start = 0; n_done = 0; n_busy = m_busy; n_snap = 0;
      for (int k = 0; k < NUM; k++) begin
        if (clr) cm[k] = 0;
        else if (evt[k] && cm[k] != MAXC) cm[k] = cm[k] + 1;
      end
      if (m_snap) begin
        expq.delete();
        expq.push_back(8'hA5);
        cs = 8'h00;
        for (int k = 0; k < NUM; k++)
          for (int b = BPC - 1; b >= 0; b--) begin
            expq.push_back(8'((cm[k] >> (8 * b)) & 64'hFF));
            cs = cs ^ 8'((cm[k] >> (8 * b)) & 64'hFF);
          end
`ifdef PERF_CHECKSUM_EN
        expq.push_back(cs);
`endif
        n_start = 1;
        m_data  = expq.pop_front();
      end else if (m_since >= 2 && !txb) begin
        if (expq.size() > 0) begin
          n_start = 1;
          m_data  = expq.pop_front();
        end else begin
          n_done = 1;
        end
      end
      if (m_done) n_busy = 0;
      if (!m_busy && dump) begin
        n_busy = 1;
        n_snap = 1;
      end
      if (n_start) m_since = 0;
      else if (m_since >= 0) m_since++;
      if (n_done) m_since = -1;
      m_busy = n_busy; m_start = n_start; m_done = n_done; m_snap = n_snap;
    end
  end

  int ev0 = 0;

  // drive one cycle of inputs; called at posedge+2
  task automatic step(input logic [NUM-1:0] e, input logic c, input logic d);
    evt = e; clr = c; dump = d;
    if (c) ev0 = 0;
    else if (e[0]) ev0++;
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input logic [NUM-1:0] e, input bit pulse, input string nm);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 4000) begin
      step(e, 1'b0, pulse && (busy === 1'b1) && (n % 5 == 2));
      n++;
    end
    check(nm, {63'd0, done_cnt != start}, 64'd1);
    step('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] acc;
    int n;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_data", {56'd0, data}, 64'd0);
    rstn = 1'b1;
    step('0, 1'b0, 1'b0);

    // T1: ch0 x3, ch2 x260
    repeat (3) step(8'h01, 1'b0, 1'b0);
    repeat (260) step(8'h04, 1'b0, 1'b0);
    cap.delete(); done_cnt = 0;
    step('0, 1'b0, 1'b1);
    wait_done('0, 1'b0, "t1_timeout");
    check("t1_len", cap.size(), LEN);
    check("t1_hdr", cb(0), 64'hA5);
    check("t1_ch0", cb(4), 64'h03);
    check("t1_ch2_b2", cb(11), 64'h01);
    check("t1_ch2_b3", cb(12), 64'h04);
    check("t1_tail", cb(32), 64'h00);
    check("t1_done_cnt", done_cnt, 1);
`ifdef PERF_CHECKSUM_EN
    check("t1_csum", cb(33), 64'h06);
`endif

    // T3: clear collides with an event on ch3
    step('0, 1'b1, 1'b0);
    repeat (5) step(8'h08, 1'b0, 1'b0);
    step(8'h08, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b0);
    cap.delete(); done_cnt = 0;
    step('0, 1'b0, 1'b1);
    wait_done('0, 1'b0, "t3_timeout");
    check("t3_ch3_hi", cb(15), 64'h00);
    check("t3_ch3_lo", cb(16), 64'h01);
    check("t3_ch0_cleared", cb(4), 64'h00);

    // T4: events and repeated dumps while a frame is in flight
    step('0, 1'b1, 1'b0);
    repeat (5) step(8'h01, 1'b0, 1'b0);
    cap.delete(); done_cnt = 0;
    step(8'h01, 1'b0, 1'b1);
    wait_done(8'h01, 1'b1, "t4_timeout");
    check("t4_one_frame_len", cap.size(), LEN);
    check("t4_one_done", done_cnt, 1);
    check("t4_snap", {cb(1)[7:0], cb(2)[7:0], cb(3)[7:0], cb(4)[7:0]}, 64'd7);
    repeat (4) step('0, 1'b0, 1'b0);
    check("t4_idle_after", {63'd0, busy}, 64'd0);
    cap.delete(); done_cnt = 0;
    step('0, 1'b0, 1'b1);
    wait_done('0, 1'b0, "t4b_timeout");
    check("t4_second", {cb(1)[7:0], cb(2)[7:0], cb(3)[7:0], cb(4)[7:0]}, 64'(ev0));

    // T5: reset while byte 7 is being launched
    cap.delete(); done_cnt = 0;
    step('0, 1'b0, 1'b1);
    n = 0;
    while (!(txs === 1'b1 && cap.size() == 6) && n < 2000) begin
      step('0, 1'b0, 1'b0);
      n++;
    end
    check("t5_reached_byte7", {63'd0, n < 2000}, 64'd1);
    rstn = 1'b0;
    #1;
    check("t5_start_low", {63'd0, txs}, 64'd0);
    check("t5_busy_low", {63'd0, busy}, 64'd0);
    @(posedge clk); @(posedge clk); #2;
    rstn = 1'b1;
    step('0, 1'b0, 1'b0);
    cap.delete(); done_cnt = 0;
    step('0, 1'b0, 1'b1);
    wait_done('0, 1'b0, "t5_timeout");
    check("t5_len", cap.size(), LEN);
    acc = 64'd0;
    for (int i = 1; i < cap.size(); i++) acc = acc | {56'd0, cap[i]};
    check("t5_zeros", acc, 64'd0);

    // T2: 8-bit counters saturate
    cap8.delete(); done8_cnt = 0;
    evt8 = 2'b10;
    repeat (300) step('0, 1'b0, 1'b0);
    evt8 = 2'b00;
    dump8 = 1'b1;
    step('0, 1'b0, 1'b0);
    dump8 = 1'b0;
    n = 0;
    while (done8_cnt == 0 && n < 200) begin
      step('0, 1'b0, 1'b0);
      n++;
    end
    check("t2_done", done8_cnt, 1);
    check("t2_len", cap8.size(), LEN8);
    if (cap8.size() >= 3) begin
      check("t2_hdr", {56'd0, cap8[0]}, 64'hA5);
      check("t2_ch0", {56'd0, cap8[1]}, 64'h00);
      check("t2_ch1_sat", {56'd0, cap8[2]}, 64'hFF);
    end

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) hold_len = $urandom_range(0, 12);
      step(NUM'($urandom & $urandom), ($urandom_range(0, 63) == 0), ($urandom_range(0, 19) == 0));
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      step('0, 1'b0, 1'b0);
      n++;
    end
    check("drain_idle", {63'd0, busy}, 64'd0);
    repeat (3) step('0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
